// File: rtl/dpmem_stream_fifo_if.sv
// Stream and dual-port memory signals for dpmem_stream_fifo.
// master = the FIFO controller; slave = the producer/consumer/memory side.
interface dpmem_stream_fifo_if #(
  parameter int addrW = 8,
  parameter int dataW = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [dataW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [dataW-1:0] out_data;
  logic             EnA;
  logic             wEnA;
  logic [addrW-1:0] addrA;
  logic [dataW-1:0] dInA;
  logic             EnB;
  logic             wEnB;
  logic [addrW-1:0] addrB;
  logic [dataW-1:0] dOutB;
  logic             collision;

  modport master (
    input  in_valid, in_data, out_ready, dOutB, collision,
    output in_ready, out_valid, out_data, EnA, wEnA, addrA, dInA, EnB, wEnB, addrB
  );

  modport slave (
    output in_valid, in_data, out_ready, dOutB, collision,
    input  in_ready, out_valid, out_data, EnA, wEnA, addrA, dInA, EnB, wEnB, addrB
  );
endinterface

// File: rtl/dpmem_stream_fifo.sv
// Stream FIFO over a dual-port memory: pushes write port A, port B reads refill a
// 2-entry registered output buffer (push-to-out_valid latency 3 cycles).
module dpmem_stream_fifo #(
  parameter int addrW = 8,
  parameter int dataW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dpmem_stream_fifo_if.master bus,
  output logic [addrW:0]      count,
  output logic                full,
  output logic                empty,
  output logic                err
);
  localparam logic [addrW:0] depth  = {1'b1, {addrW{1'b0}}};
  localparam logic [addrW:0] ptrOne = {{addrW{1'b0}}, 1'b1};

  logic [addrW:0]   wrPtr;
  logic [addrW:0]   rdPtr;
  logic [addrW:0]   cnt;
  logic             inflight;
  logic [1:0]       bufCnt;
  logic [dataW-1:0] buf0;
  logic [dataW-1:0] buf1;
  logic             errQ;
  logic             push;
  logic             pop;
  logic             issue;
  logic [1:0]       occAfterPop;

  assign full  = (cnt == depth);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign err   = errQ;

  assign bus.in_ready = !full && rst_n;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  // Words committed to the buffer once the pending read lands; at most 2 ever fit.
  assign occAfterPop = bufCnt + {1'b0, inflight} - {1'b0, pop};
  assign issue       = rst_n && !empty && (occAfterPop < 2'd2);

  assign bus.EnA   = push;
  assign bus.wEnA  = push;
  assign bus.addrA = wrPtr[addrW-1:0];
  assign bus.dInA  = push ? bus.in_data : '0;
  assign bus.EnB   = issue;
  assign bus.wEnB  = 1'b0;
  assign bus.addrB = rdPtr[addrW-1:0];

  assign bus.out_valid = (bufCnt != 2'd0);
  assign bus.out_data  = buf0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + ptrOne;
      if (issue)
        rdPtr <= rdPtr + ptrOne;
      if (push && !issue)
        cnt <= cnt + ptrOne;
      else if (issue && !push)
        cnt <= cnt - ptrOne;
      inflight <= issue;
      // Same-address access cannot happen by construction, so any report is fatal.
      if (bus.collision)
        errQ <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufCnt <= 2'd0;
      buf0   <= '0;
      buf1   <= '0;
    end else begin
      case ({inflight, pop})
        2'b11: begin
          if (bufCnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= bus.dOutB;
          end else begin
            buf0 <= bus.dOutB;
          end
        end
        2'b10: begin
          if (bufCnt == 2'd0)
            buf0 <= bus.dOutB;
          else
            buf1 <= bus.dOutB;
          bufCnt <= bufCnt + 2'd1;
        end
        2'b01: begin
          buf0   <= buf1;
          bufCnt <= bufCnt - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/dpmem_stream_fifo.md
# dpmem_stream_fifo

Stream-to-memory FIFO controller sitting directly upstream of the dual-port memory. It turns a valid/ready input stream into port-A writes and drains the stored words back out through port-B reads into a valid/ready output stream. Port A is write-only, port B is read-only, and the block owns the address pointers. It also flags any memory collision report as a fatal error, because correct operation never produces one.

## Interface
Parameters:
- addrW, 8: memory address width; depth = 2**addrW entries.
- dataW, 16: data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  dataW  input word.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts output this cycle.
- out_data  out  dataW  output word.
- EnA, wEnA  out  1 each  memory port-A enable and write enable.
- addrA  out  addrW  port-A address.
- dInA  out  dataW  port-A write data.
- EnB, wEnB  out  1 each  memory port-B enable and write enable; wEnB is tied 0.
- addrB  out  addrW  port-B address.
- dOutB  in  dataW  port-B read data, registered in memory, valid the cycle after EnB.
- collision  in  1  memory same-address report.
- count  out  addrW+1  words currently held in memory, 0..depth.
- full, empty  out  1 each  count==depth, count==0.
- err  out  1  sticky; set when collision is seen high.

## Operation
- Write side:
  - in_ready = !full && rst_n.
  - A push is in_valid && in_ready.
  - On a push: EnA=wEnA=1, addrA=wr_ptr[addrW-1:0] and dInA=in_data, all combinational in the same cycle. wr_ptr increments at the edge.
- Read issue:
  - issue = !empty && (buf_cnt + inflight − pop) < 2, where pop = out_valid && out_ready.
  - On issue: EnB=1, addrB=rd_ptr[addrW-1:0]. rd_ptr increments and the inflight flag is set at the edge.
- Capture: when inflight is 1, dOutB is written into the 2-entry output buffer tail at the edge, and inflight clears unless a new issue occurs.
- Output buffer:
  - 2-entry FIFO; out_valid = buf_cnt != 0; out_data = head, registered.
  - Pop and capture in the same cycle are both honoured.
- Count: count += push, −= issue. Simultaneous push and issue leaves count unchanged.
- Pointers: wr_ptr and rd_ptr are addrW+1 bits and wrap modulo 2*depth. The address is the low addrW bits, so it wraps depth−1 → 0.
- Collision freedom: a write and a read to the same address in the same cycle needs count==0 (no read) or count==depth (no write). It is therefore impossible, and collision=1 sets err.
- err clears only on reset.

## Timing
- Reset values: in_ready=0 (during reset), out_valid=0, out_data=0, EnA=wEnA=EnB=wEnB=0, addrA=addrB=0, dInA=0, count=0, full=0, empty=1, err=0. Pointers, buf_cnt and inflight are all 0.
- Reset mid-operation clears all stored words immediately. No memory enables are asserted while rst_n=0. The first push is accepted in the first cycle with rst_n=1.
- Latency: a word pushed in cycle 0 is read-issued in cycle 1, on dOutB in cycle 2, and has out_valid=1 in cycle 3 when the output was empty.
- Throughput: one push and one pop per cycle sustained, with out_ready held at 1.
- Backpressure: with out_ready=0, at most 2 words sit in the buffer plus 0 in flight. Further words stay in memory. in_ready drops when count reaches depth, so total capacity is depth+2.
- Full: push is refused while count==depth, even if an issue occurs the same cycle. in_ready recovers the cycle after count drops.
- Empty: no issue when count==0, even if a push occurs the same cycle. A same-cycle push is readable from the next cycle.
- out_valid, once high, stays high with stable out_data until popped.

## Test plan
- Reset, push 0x0002 with out_ready=1 → EnA=wEnA=1 and addrA=0 in cycle 0, EnB=1 and addrB=0 in cycle 1, out_valid=1 with out_data=0x0002 in cycle 3, count returns to 0.
- addrW=2, out_ready=0, push 0x10..0x17 → buffer holds 0x10 and 0x11, memory holds 0x12..0x15, full=1, in_ready=0, 0x16 stalls. Then out_ready=1 → 0x10..0x17 emerge in order and addrA wraps 3 → 0.
- Continuous push/pop of 256 incrementing words, addrW=8 → one output per cycle after 3-cycle fill, in order, count ≤ 1, err=0.
- Random in_valid/out_ready at 50% each over 2000 words → output order matches a scoreboard, no word lost or duplicated, out_data stable while stalled.
- Pulse collision=1 for one cycle → err=1 from the next cycle and stays 1 until rst_n=0.
- Assert rst_n=0 for 1 cycle with 5 words held → out_valid=0, count=0, empty=1 immediately. A subsequent push of 0x0007 emerges as the next output.
